lcd_de_rx: RTL
==============

# lcd_de_rx

DE-mode parallel RGB video receiver: the sink end of the LCD panel interface that our pixel pipeline drives (24-bit RGB plus an ENB/DE qualifier, one pixel per `pixel_clk`). It recovers frame and line boundaries from DE alone, re-derives pixel/row coordinates, and emits a registered pixel stream. It also measures active width and height and flags timing violations. It is used as a loopback checker on the LCD output bank and as the front end of a future video-capture path.

## Interface
- `LCD_WIDTH`, 640: expected active pixels per line.
- `LCD_HEIGHT`, 480: expected active lines per frame.
- `VBLANK_THRESH`, 1024: consecutive DE-low cycles that mark vertical blanking. Must exceed the horizontal blanking time (160) and be less than the vertical blanking time (45 × 800).
- `pixel_clk`  input  1  the single clock. All logic is on its rising edge.
- `rst`  input  1  synchronous, active-low reset. The block is in reset while `rst` = 0.
- `de`  input  1  data enable (ENB). High during active pixels.
- `rgb_in`  input  24  pixel data as {R[7:0], G[7:0], B[7:0]}. Valid when `de` = 1.
- `pix_valid`  output  1  a pixel is presented this cycle.
- `pix_rgb`  output  24  pixel data.
- `pix_x`  output  10  pixel column, 0..LCD_WIDTH-1.
- `pix_y`  output  10  pixel row, 0..LCD_HEIGHT-1.
- `sof`  output  1  first pixel of a frame. Pulses together with `pix_valid`.
- `eol`  output  1  last presented pixel of a line. Pulses together with `pix_valid`.
- `locked`  output  1  the last completed frame had exact geometry.
- `line_len_err`  output  1  sticky: a line length was not LCD_WIDTH.
- `frame_err`  output  1  sticky: a frame line count was not LCD_HEIGHT.
- `meas_width`  output  11  length of the last completed line. Saturates at 2047.
- `meas_height`  output  11  line count of the last completed frame. Saturates at 2047.

## Operation
- Input stage: `de` and `rgb_in` are registered once. All decisions use the registered values.
- `low_cnt` (16 bits) counts consecutive DE-low cycles. It clears when DE is high and saturates at VBLANK_THRESH.
- `x_cnt` and `y_cnt` are 11 bits each and saturate. They track position within the line and frame.
- FSM states:
  - SEARCH (reset state): DE is ignored and `pix_valid` = 0. When `low_cnt` reaches VBLANK_THRESH, go to VBLANK.
  - VBLANK: waits for DE. On DE = 1, go to ACTIVE with x = 0, y = 0, and `sof` asserted on that pixel.
  - ACTIVE: DE = 1 presents the pixel and increments x. On DE falling:
    - `meas_width` ← x_cnt.
    - `line_len_err` is set if x_cnt ≠ LCD_WIDTH.
    - y increments, and the FSM goes to HGAP.
  - HGAP: DE = 1 starts a new line at x = 0, and the FSM goes to ACTIVE. If `low_cnt` reaches VBLANK_THRESH first, the frame ends:
    - `meas_height` ← y_cnt.
    - `frame_err` is set if y_cnt ≠ LCD_HEIGHT.
    - `locked` ← 1 only if no line in this frame had a length error and y_cnt = LCD_HEIGHT. Otherwise `locked` ← 0.
    - The FSM goes to VBLANK.
- Suppression: a pixel with x ≥ LCD_WIDTH or y ≥ LCD_HEIGHT is not presented (`pix_valid` = 0), but counting continues.
- `eol` asserts on the last presented pixel of a line. That is the pixel at x = LCD_WIDTH-1, or the final pixel of a short line.
  - For a short line, `eol` is output one cycle after that pixel would otherwise be presented. The presented pixel is held one cycle so that `eol` is known. A one-pixel skid register achieves this.
  - Because of this, the output latency is a fixed 2 cycles for every pixel.
- Error flags are sticky. Only reset clears them. `locked` re-asserts after the next good frame even while the error flags remain set.

## Timing
- Reset (`rst` = 0 at a clock edge): on the next edge every output is 0, including `meas_*`. The FSM is in SEARCH and all counters are 0.
  - Reset mid-line or mid-frame behaves the same way. The block then needs a full VBLANK_THRESH low run before presenting any pixel.
- Latency: `de`/`rgb_in` sampled at edge n produce `pix_valid`/`pix_rgb` valid after edge n+2. `sof`, `eol`, `pix_x` and `pix_y` follow the same alignment.
- `meas_width` and `line_len_err` update 2 cycles after DE falls.
- `meas_height`, `frame_err` and `locked` update 2 cycles after `low_cnt` reaches the threshold.
- Simultaneous events: a one-pixel line asserts `sof` and `eol` on the same pixel. A DE rise in the same cycle that `low_cnt` reaches the threshold counts as a new line, not a frame end.
- Nominal stream: 640 active + 160 blanking per line, 480 active + 45 blanking lines. That gives 800 × 525 cycles per frame.

## Test plan
- Reset: hold `rst` = 0 for 3 cycles while driving random DE/RGB. Required: all outputs 0 throughout, and 0 on the first cycle after release.
- Nominal: drive 2000 DE-low cycles, then 2 nominal frames with RGB = {y[7:0], x[7:0], 8'hA5}. Required:
  - 640 × 480 `pix_valid` per frame, each with the matching x, y and RGB.
  - One `sof` per frame and 480 `eol` per frame.
  - `locked` = 1 after frame 1; `meas_width` = 640; `meas_height` = 480; no errors.
- Short line: row 10 has 639 pixels. Required:
  - `line_len_err` = 1.
  - `eol` at x = 638 on row 10.
  - `meas_width` = 639 after that line.
  - `locked` = 0 at the end of the frame.
- Long line: row 20 has 645 pixels. Required: no `pix_valid` for x = 640..644, `line_len_err` = 1, `meas_width` = 645.
- Short frame: 479 lines, then one nominal frame. Required: `frame_err` = 1 and `meas_height` = 479, then `locked` = 1 after the good frame while `frame_err` stays 1.
- Mid-frame reset: pulse `rst` = 0 for 1 cycle at row 100, x 300. Required:
  - All outputs 0 on the next cycle.
  - No `pix_valid` for the rest of that frame.
  - Capture resumes with `sof` at the start of the next frame.

Source files
------------

// File: rtl/lcd_de_rx.sv
// lcd_de_rx -- DE-mode parallel RGB video receiver.
//
// Recovers frame and line structure from the DE qualifier alone, assigns
// pixel/row coordinates, and emits a registered pixel stream with
// start-of-frame and end-of-line markers. It also measures the active
// geometry and keeps sticky flags for length violations.
//
// Ports
//   pixel_clk    : the only clock, rising edge
//   rst          : synchronous reset, active low
//   de, rgb_in   : incoming DE and {R,G,B} pixel data
//   pix_valid    : a pixel is presented this cycle
//   pix_rgb      : presented pixel data
//   pix_x, pix_y : presented pixel coordinates
//   sof, eol     : first pixel of frame / last presented pixel of line
//   locked       : last completed frame had exact geometry
//   line_len_err : sticky, some line length differed from LCD_WIDTH
//   frame_err    : sticky, some frame line count differed from LCD_HEIGHT
//   meas_width   : length of the last completed line (saturating)
//   meas_height  : line count of the last completed frame (saturating)
//
// Pipeline: input register -> decode/skid register -> output register.
// Every pixel leaves exactly two edges after it was sampled, because the
// skid stage holds each pixel one cycle until it is known whether the line
// ends behind it (which is what drives eol on short lines).
module lcd_de_rx #(
  parameter int LCD_WIDTH     = 640,
  parameter int LCD_HEIGHT    = 480,
  parameter int VBLANK_THRESH = 1024
) (
  input  logic        pixel_clk,
  input  logic        rst,
  input  logic        de,
  input  logic [23:0] rgb_in,
  output logic        pix_valid,
  output logic [23:0] pix_rgb,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        sof,
  output logic        eol,
  output logic        locked,
  output logic        line_len_err,
  output logic        frame_err,
  output logic [10:0] meas_width,
  output logic [10:0] meas_height
);

  localparam logic [10:0] W11    = 11'(LCD_WIDTH);
  localparam logic [10:0] H11    = 11'(LCD_HEIGHT);
  localparam logic [9:0]  X_LAST = 10'(LCD_WIDTH - 1);
  localparam logic [15:0] THR    = 16'(VBLANK_THRESH);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VBLANK = 2'd1,
    ACTIVE = 2'd2,
    HGAP   = 2'd3
  } state_t;

  typedef struct packed {
    logic        vld;
    logic        sof;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] rgb;
  } pix_t;

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  // Input stage
  logic        r_de;
  logic [23:0] r_rgb;
  logic [15:0] r_low;     // consecutive registered-DE-low samples, saturating

  // Frame/line tracking
  state_t      r_state, w_state_nxt;
  logic [10:0] r_x;       // pixels accepted so far in the current line
  logic [10:0] r_y;       // lines completed so far in the current frame
  logic        r_line_bad;// some line of the current frame had a bad length
  pix_t        r_skid;

  // Decode of the current cycle
  logic        w_take;      // registered DE carries a pixel we are tracking
  logic        w_new_frame; // that pixel opens a frame
  logic        w_line_end;  // DE fell: the pixel in r_skid closed its line
  logic        w_frame_end; // blanking long enough to close the frame
  logic [10:0] w_px, w_py;
  logic        w_show;
  logic        w_low_sat;

  assign w_low_sat = (r_low == THR);

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_new_frame = 1'b0;
    w_line_end  = 1'b0;
    w_frame_end = 1'b0;
    unique case (r_state)
      SEARCH: begin
        // A rise coinciding with the end of the first long low run can
        // already be taken as the first pixel of a frame.
        if (w_low_sat) begin
          if (r_de) begin
            w_take      = 1'b1;
            w_new_frame = 1'b1;
            w_state_nxt = ACTIVE;
          end else begin
            w_state_nxt = VBLANK;
          end
        end
      end
      VBLANK: begin
        if (r_de) begin
          w_take      = 1'b1;
          w_new_frame = 1'b1;
          w_state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        if (r_de) begin
          w_take = 1'b1;
        end else begin
          w_line_end  = 1'b1;
          w_state_nxt = HGAP;
        end
      end
      HGAP: begin
        // DE is checked first so a rise on the threshold cycle is a new line.
        if (r_de) begin
          w_take      = 1'b1;
          w_state_nxt = ACTIVE;
        end else if (w_low_sat) begin
          w_frame_end = 1'b1;
          w_state_nxt = VBLANK;
        end
      end
      default: w_state_nxt = SEARCH;
    endcase
  end

  // Only a continuing line keeps its column; any other entry starts at 0.
  assign w_px   = (r_state == ACTIVE) ? r_x : 11'd0;
  assign w_py   = w_new_frame ? 11'd0 : r_y;
  assign w_show = w_take && (w_px < W11) && (w_py < H11);

  always_ff @(posedge pixel_clk) begin
    if (!rst) begin
      r_state <= SEARCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (!rst) begin
      r_de  <= 1'b0;
      r_rgb <= '0;
      r_low <= '0;
    end else begin
      r_de  <= de;
      r_rgb <= rgb_in;
      if (r_de)            r_low <= '0;
      else if (!w_low_sat) r_low <= r_low + 16'd1;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (!rst) begin
      r_x          <= '0;
      r_y          <= '0;
      r_line_bad   <= 1'b0;
      meas_width   <= '0;
      meas_height  <= '0;
      line_len_err <= 1'b0;
      frame_err    <= 1'b0;
      locked       <= 1'b0;
    end else begin
      if (w_take) begin
        r_x <= sat_inc(w_px);
        r_y <= w_py;
      end
      if (w_new_frame) r_line_bad <= 1'b0;
      if (w_line_end) begin
        r_y        <= sat_inc(r_y);
        meas_width <= r_x;
        if (r_x != W11) begin
          line_len_err <= 1'b1;
          r_line_bad   <= 1'b1;
        end
      end
      if (w_frame_end) begin
        meas_height <= r_y;
        if (r_y != H11) frame_err <= 1'b1;
        locked <= !r_line_bad && (r_y == H11);
      end
    end
  end

  // Skid stage holds the decoded pixel one cycle; the output stage adds eol
  // once the following cycle shows whether the line ended.
  always_ff @(posedge pixel_clk) begin
    if (!rst) begin
      r_skid    <= '0;
      pix_valid <= 1'b0;
      pix_rgb   <= '0;
      pix_x     <= '0;
      pix_y     <= '0;
      sof       <= 1'b0;
      eol       <= 1'b0;
    end else begin
      r_skid.vld <= w_show;
      r_skid.sof <= w_show && w_new_frame;
      r_skid.x   <= w_px[9:0];
      r_skid.y   <= w_py[9:0];
      r_skid.rgb <= r_rgb;
      pix_valid  <= r_skid.vld;
      pix_rgb    <= r_skid.rgb;
      pix_x      <= r_skid.x;
      pix_y      <= r_skid.y;
      sof        <= r_skid.sof;
      eol        <= r_skid.vld && ((r_skid.x == X_LAST) || w_line_end);
    end
  end

endmodule
